// File: rtl/sopc_data_bus.sv
// Data-side interconnect: decodes CPU accesses onto N_SLV req/ack slaves, flags decode misses and timeouts.
// Latency 3 cycles request-to-DONE for a zero-wait slave; the CPU is stalled (m_stall) until DONE.
module sopc_data_bus #(
   parameter int                  DW       = 32,
   parameter int                  AW       = 32,
   parameter int                  N_SLV    = 4,
   parameter logic [N_SLV*AW-1:0] SLV_BASE = '0,
   parameter logic [N_SLV*AW-1:0] SLV_MASK = '0,
   parameter int                  TIMEOUT  = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                m_ce,
   input  logic                m_we,
   input  logic [AW-1:0]       m_addr,
   input  logic [DW/8-1:0]     m_sel,
   input  logic [DW-1:0]       m_wdata,
   output logic [DW-1:0]       m_rdata,
   output logic                m_stall,
   output logic                m_err,
   output logic [AW-1:0]       err_addr,
   output logic [N_SLV-1:0]    s_req,
   output logic                s_we,
   output logic [AW-1:0]       s_addr,
   output logic [DW/8-1:0]     s_sel,
   output logic [DW-1:0]       s_wdata,
   input  logic [N_SLV*DW-1:0] s_rdata,
   input  logic [N_SLV-1:0]    s_ack
);
   localparam int SW = DW / 8;
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

   typedef struct packed {
      logic          we;
      logic [AW-1:0] addr;
      logic [SW-1:0] sel;
      logic [DW-1:0] wdata;
   } req_t;

   state_t           state_q, state_d;
   req_t             req_q;
   logic [N_SLV-1:0] hit_vec, dec_oh;
   logic             hit, found, ack, tmo;
   logic [DW-1:0]    ack_rdata;
   logic [CW-1:0]    cnt_q;

   always_comb begin
      hit_vec = '0;
      for (int i = 0; i < N_SLV; i++)
         hit_vec[i] = ((m_addr & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW]);
   end

   // Overlapping regions resolve to the lowest slave index.
   always_comb begin
      dec_oh = '0;
      found  = 1'b0;
      for (int i = 0; i < N_SLV; i++) begin
         if (!found && hit_vec[i]) begin
            dec_oh[i] = 1'b1;
            found     = 1'b1;
         end
      end
   end

   assign hit = |hit_vec;

   // s_req is non-zero only in WAIT, so masking acks with it rejects strays and idle-time acks.
   assign ack = |(s_ack & s_req);
   assign tmo = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1)) && !ack;

   always_comb begin
      ack_rdata = '0;
      for (int i = 0; i < N_SLV; i++)
         if (s_req[i]) ack_rdata = ack_rdata | s_rdata[i*DW +: DW];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= ST_IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      m_stall = 1'b0;
      case (state_q)
         ST_IDLE: begin
            m_stall = m_ce;
            if (m_ce) state_d = hit ? ST_WAIT : ST_DONE;
         end
         ST_WAIT: begin
            m_stall = 1'b1;
            if (ack || tmo) state_d = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         req_q    <= '0;
         s_req    <= '0;
         cnt_q    <= '0;
         m_rdata  <= '0;
         m_err    <= 1'b0;
         err_addr <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (m_ce) begin
                  req_q <= '{we: m_we, addr: m_addr, sel: m_sel, wdata: m_wdata};
                  s_req <= dec_oh;
                  cnt_q <= '0;
                  if (!hit) begin
                     m_err    <= 1'b1;
                     m_rdata  <= '0;
                     err_addr <= m_addr;
                  end
               end
            end
            ST_WAIT: begin
               cnt_q <= cnt_q + CW'(1);
               if (ack) begin
                  s_req   <= '0;
                  m_err   <= 1'b0;
                  m_rdata <= req_q.we ? '0 : ack_rdata;
               end else if (tmo) begin
                  s_req    <= '0;
                  m_err    <= 1'b1;
                  m_rdata  <= '0;
                  err_addr <= req_q.addr;
               end
            end
            ST_DONE: cnt_q <= '0;
            default: ;
         endcase
      end
   end

   assign s_we    = req_q.we;
   assign s_addr  = req_q.addr;
   assign s_sel   = req_q.sel;
   assign s_wdata = req_q.wdata;

endmodule

// File: tb/tb_sopc_data_bus.sv
// Bench for sopc_data_bus: transaction-level model predicts per-cycle stall/s_req and completion results;
// reactive slave models supply acks after a configured number of wait cycles.
module tb_sopc_data_bus;
   localparam int TMO = 16;
   localparam logic [31:0] BASE_A [4] = '{32'h0000_0000, 32'h1000_0000, 32'h0000_0000, 32'h2000_0000};
   localparam logic [31:0] MASK_A [4] = '{32'hFFFF_0000, 32'hFFFF_0000, 32'hF000_0000, 32'hFFFF_0000};

   logic         clk, rst;
   logic         m_ce, m_we;
   logic [31:0]  m_addr, m_wdata, m_rdata, err_addr, s_addr, s_wdata;
   logic [3:0]   m_sel, s_sel, s_req, s_ack;
   logic         m_stall, m_err, s_we;
   logic [127:0] s_rdata;

   int           wait_cfg [4];
   logic [31:0]  rdat_cfg [4];
   logic [3:0]   stray;
   int           rcnt [4];

   typedef struct {
      logic        stall;
      logic [3:0]  sreq;
      logic        chk_s;
      logic        we;
      logic [31:0] addr;
      logic [3:0]  sel;
      logic [31:0] wdata;
   } exp_t;

   exp_t        e;
   logic        exp_vld;
   logic        m_err_m;
   logic [31:0] m_rdata_m, err_addr_m;
   int          n_chk, n_err, run, last_run;

   sopc_data_bus #(
      .DW(32), .AW(32), .N_SLV(4),
      .SLV_BASE({BASE_A[3], BASE_A[2], BASE_A[1], BASE_A[0]}),
      .SLV_MASK({MASK_A[3], MASK_A[2], MASK_A[1], MASK_A[0]}),
      .TIMEOUT(TMO)
   ) dut (
      .clk(clk), .rst(rst),
      .m_ce(m_ce), .m_we(m_we), .m_addr(m_addr), .m_sel(m_sel), .m_wdata(m_wdata),
      .m_rdata(m_rdata), .m_stall(m_stall), .m_err(m_err), .err_addr(err_addr),
      .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_sel(s_sel), .s_wdata(s_wdata),
      .s_rdata(s_rdata), .s_ack(s_ack)
   );

   assign s_rdata = {rdat_cfg[3], rdat_cfg[2], rdat_cfg[1], rdat_cfg[0]};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h at %0t", nm, act, req, $time);
      end
   endtask

   // Slave i acks in its (wait_cfg[i]+1)-th consecutive request cycle.
   initial begin
      s_ack = '0;
      for (int i = 0; i < 4; i++) rcnt[i] = 0;
      forever begin
         @(posedge clk);
         #1;
         for (int i = 0; i < 4; i++) begin
            rcnt[i] = s_req[i] ? rcnt[i] + 1 : 0;
            s_ack[i] = s_req[i] && (rcnt[i] == wait_cfg[i] + 1);
         end
         s_ack = s_ack | stray;
      end
   end

   initial begin
      run = 0;
      last_run = 0;
      forever begin
         @(negedge clk);
         if (exp_vld) begin
            chk("m_stall", 32'(m_stall), 32'(e.stall));
            chk("s_req", 32'(s_req), 32'(e.sreq));
            chk("m_err", 32'(m_err), 32'(m_err_m));
            chk("m_rdata", m_rdata, m_rdata_m);
            chk("err_addr", err_addr, err_addr_m);
            if (e.chk_s) begin
               chk("s_we", 32'(s_we), 32'(e.we));
               chk("s_addr", s_addr, e.addr);
               chk("s_sel", 32'(s_sel), 32'(e.sel));
               chk("s_wdata", s_wdata, e.wdata);
            end
         end
         if (m_stall) run++;
         else if (run != 0) begin
            last_run = run;
            run = 0;
         end
      end
   end

   function automatic int decode(input logic [31:0] a);
      for (int i = 0; i < 4; i++)
         if ((a & MASK_A[i]) == BASE_A[i]) return i;
      return -1;
   endfunction

   task automatic cyc(input logic ce, input logic we, input logic [31:0] a, input logic [3:0] sel,
                      input logic [31:0] wd, input logic stall, input logic [3:0] sreq, input logic chk_s);
      @(posedge clk);
      #1;
      m_ce = ce; m_we = we; m_addr = a; m_sel = sel; m_wdata = wd;
      e.stall = stall; e.sreq = sreq; e.chk_s = chk_s;
      e.we = we; e.addr = a; e.sel = sel; e.wdata = wd;
      exp_vld = 1'b1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 4'h0, 1'b0);
   endtask

   // One CPU access: request cycle, n request-held cycles, then the single unstalled DONE cycle.
   task automatic xfer(input logic we, input logic [31:0] a, input logic [3:0] sel, input logic [31:0] wd);
      int          tgt, n;
      logic        terr;
      logic [31:0] rd;
      logic [3:0]  oh;
      tgt = decode(a);
      oh = '0; terr = 1'b0; rd = '0; n = 0;
      if (tgt < 0) terr = 1'b1;
      else begin
         oh = 4'(1 << tgt);
         n = wait_cfg[tgt] + 1;
         if (n > TMO) begin
            n = TMO;
            terr = 1'b1;
         end else if (!we) rd = rdat_cfg[tgt];
      end
      cyc(1'b1, we, a, sel, wd, 1'b1, 4'h0, 1'b0);
      for (int k = 0; k < n; k++) cyc(1'b1, we, a, sel, wd, 1'b1, oh, 1'b1);
      cyc(1'b0, we, a, sel, wd, 1'b0, 4'h0, 1'b0);
      m_err_m = terr;
      m_rdata_m = rd;
      if (terr) err_addr_m = a;
   endtask

   initial begin
      n_chk = 0; n_err = 0; exp_vld = 1'b0;
      rst = 1'b0; m_ce = 1'b0; m_we = 1'b0; m_addr = '0; m_sel = '0; m_wdata = '0; stray = '0;
      m_err_m = 1'b0; m_rdata_m = '0; err_addr_m = '0;
      for (int i = 0; i < 4; i++) begin
         wait_cfg[i] = 0;
         rdat_cfg[i] = '0;
      end
      e = '{default: '0};

      repeat (2) @(negedge clk);
      chk("rst_s_req", 32'(s_req), 32'h0);
      chk("rst_s_addr", s_addr, 32'h0);
      chk("rst_s_wdata", s_wdata, 32'h0);
      chk("rst_s_sel_we", 32'({s_sel, s_we}), 32'h0);
      chk("rst_m_rdata", m_rdata, 32'h0);
      chk("rst_m_err", 32'(m_err), 32'h0);
      chk("rst_err_addr", err_addr, 32'h0);
      chk("rst_stall_idle", 32'(m_stall), 32'h0);
      m_ce = 1'b1;
      #1;
      chk("rst_stall_ce", 32'(m_stall), 32'h1);
      m_ce = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      idle(2);

      // zero-wait read from slave 0
      rdat_cfg[0] = 32'hA5A5_1234;
      xfer(1'b0, 32'h0000_0010, 4'hF, 32'h0);
      idle(1);
      chk("t1_stall_cycles", 32'(last_run), 32'd2);
      chk("t1_rdata", m_rdata, 32'hA5A5_1234);
      chk("t1_err", 32'(m_err), 32'h0);

      // write to slave 1 with three wait cycles
      wait_cfg[1] = 3;
      rdat_cfg[1] = 32'h1111_0001;
      xfer(1'b1, 32'h1000_0004, 4'b0011, 32'hCAFE_BEEF);
      idle(1);
      chk("t2_stall_cycles", 32'(last_run), 32'd5);
      chk("t2_rdata_write", m_rdata, 32'h0);
      chk("t2_err", 32'(m_err), 32'h0);

      // unmapped address
      xfer(1'b0, 32'hF000_0000, 4'hF, 32'h0);
      idle(1);
      chk("t3_stall_cycles", 32'(last_run), 32'd1);
      chk("t3_err", 32'(m_err), 32'h1);
      chk("t3_err_addr", err_addr, 32'hF000_0000);
      chk("t3_rdata", m_rdata, 32'h0);

      // timeout, then ack exactly in the last allowed cycle
      wait_cfg[3] = 1000;
      rdat_cfg[3] = 32'h3333_0016;
      xfer(1'b0, 32'h2000_0008, 4'hF, 32'h0);
      idle(1);
      chk("t4_tmo_stall_cycles", 32'(last_run), 32'd17);
      chk("t4_tmo_err", 32'(m_err), 32'h1);
      chk("t4_tmo_err_addr", err_addr, 32'h2000_0008);
      wait_cfg[3] = 15;
      xfer(1'b0, 32'h2000_0008, 4'hF, 32'h0);
      idle(1);
      chk("t4_late_ack_stall_cycles", 32'(last_run), 32'd17);
      chk("t4_late_ack_err", 32'(m_err), 32'h0);
      chk("t4_late_ack_rdata", m_rdata, 32'h3333_0016);

      // overlapping slaves 0 and 2 with a stray ack from slave 2
      wait_cfg[0] = 2;
      rdat_cfg[0] = 32'h0000_5A5A;
      rdat_cfg[2] = 32'h2222_2222;
      stray = 4'b0100;
      xfer(1'b0, 32'h0000_0100, 4'hF, 32'h0);
      stray = 4'b0000;
      idle(1);
      chk("t5_overlap_rdata", m_rdata, 32'h0000_5A5A);
      chk("t5_overlap_stall_cycles", 32'(last_run), 32'd4);

      // back-to-back: slave 0, slave 2 only, then a miss with no idle gaps
      wait_cfg[0] = 0;
      xfer(1'b0, 32'h0000_0200, 4'hF, 32'h0);
      xfer(1'b0, 32'h0100_0000, 4'hF, 32'h0);
      xfer(1'b0, 32'h3000_0000, 4'hF, 32'h0);

      // reset while waiting on slave 1
      wait_cfg[1] = 40;
      cyc(1'b1, 1'b0, 32'h1000_0020, 4'hF, 32'h0, 1'b1, 4'h0, 1'b0);
      cyc(1'b1, 1'b0, 32'h1000_0020, 4'hF, 32'h0, 1'b1, 4'b0010, 1'b1);
      cyc(1'b1, 1'b0, 32'h1000_0020, 4'hF, 32'h0, 1'b1, 4'b0010, 1'b1);
      @(posedge clk);
      #1;
      exp_vld = 1'b0;
      m_ce = 1'b0;
      rst = 1'b0;
      #1;
      chk("t6_s_req_async", 32'(s_req), 32'h0);
      chk("t6_stall", 32'(m_stall), 32'h0);
      chk("t6_err_cleared", 32'(m_err), 32'h0);
      m_err_m = 1'b0; m_rdata_m = '0; err_addr_m = '0;
      idle(2);
      rst = 1'b1;
      idle(1);
      wait_cfg[1] = 1;
      xfer(1'b0, 32'h1000_0020, 4'hF, 32'h0);
      idle(1);
      chk("t6_after_rst_rdata", m_rdata, 32'h1111_0001);
      chk("t6_after_rst_stall_cycles", 32'(last_run), 32'd3);
      idle(2);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
